// File: rtl/mux_pipe_pkg.sv
// Shared helpers for the muxed pipeline register: select-width function and default data width.
package mux_pipe_pkg;

    localparam int unsigned DefaultWidth = 8;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One data+valid pipeline register with rst > flush > en > hold priority.
module mux_pipe_stage #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else if (en) begin
            q     <= d;
            q_vld <= vld;
        end
    end

endmodule

// File: rtl/mux_pipe_reg.sv
// NUM_IN:1 select feeding a DEPTH-stage registered pipeline with valid, stall, flush and a
// sticky out-of-range select flag.
module mux_pipe_reg
    import mux_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH   = DefaultWidth,
    parameter int unsigned       NUM_IN  = 2,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [sel_w(NUM_IN)-1:0]  sel,
    input  logic [NUM_IN*WIDTH-1:0]   d,
    input  logic                      in_valid,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic                      sel_err
);

    logic [31:0]      sel_ext;
    logic             sel_ok;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] data_chain [DEPTH+1];
    logic             vld_chain  [DEPTH+1];
    logic             sel_err_q;

    assign sel_ext = 32'(sel);
    assign sel_ok  = (sel_ext < NUM_IN);

    // Out-of-range selects fall through to RST_VAL so a bubble carries a known value.
    always_comb begin
        mux_out = RST_VAL;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel_ext == i) begin
                mux_out = d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign data_chain[0] = mux_out;
    assign vld_chain[0]  = in_valid && sel_ok;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        mux_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .en    (en),
            .d     (data_chain[k]),
            .vld   (vld_chain[k]),
            .q     (data_chain[k+1]),
            .q_vld (vld_chain[k+1])
        );
    end

    // Flush suppresses the error update as well, since the sample is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (!flush && en && in_valid && !sel_ok) begin
            sel_err_q <= 1'b1;
        end
    end

    assign q       = data_chain[DEPTH];
    assign q_valid = vld_chain[DEPTH];
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg: a DEPTH=2 instance and a DEPTH=1 instance sharing stimulus.
module tb_mux_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, en, flush, in_valid;
    logic [1:0]  sel;
    logic [23:0] d;
    logic [7:0]  q2, q1;
    logic        qv2, qv1, err2, err1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(8), .NUM_IN(3), .DEPTH(2), .RST_VAL(8'h00)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .sel      (sel),
        .d        (d),
        .in_valid (in_valid),
        .q        (q2),
        .q_valid  (qv2),
        .sel_err  (err2)
    );

    mux_pipe_reg #(.WIDTH(8), .NUM_IN(3), .DEPTH(1), .RST_VAL(8'h00)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .sel      (sel),
        .d        (d),
        .in_valid (in_valid),
        .q        (q1),
        .q_valid  (qv1),
        .sel_err  (err1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs are changed at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1;
        sel = 2'($urandom_range(0, 3));
        d   = 24'($urandom);
        tick();
        d   = 24'($urandom);
        sel = 2'($urandom_range(0, 3));
        tick();
        check_val("rst_q", q2, 8'h00);
        check_val("rst_qv", qv2, 0);
        check_val("rst_err", err2, 0);
        check_val("rst_q1", q1, 8'h00);

        // Select sweep
        rst = 1'b0; in_valid = 1'b1; d = {8'hC3, 8'hB2, 8'hA1}; sel = 2'd0;
        tick();
        check_val("sweep_qv_lat", qv2, 0);
        check_val("d1_same_edge_q", q1, 8'hA1);
        check_val("d1_same_edge_qv", qv1, 1);
        sel = 2'd1;
        tick();
        check_val("sweep_q0", q2, 8'hA1);
        check_val("sweep_qv0", qv2, 1);
        sel = 2'd2;
        tick();
        check_val("sweep_q1", q2, 8'hB2);
        check_val("sweep_qv1", qv2, 1);
        in_valid = 1'b0; sel = 2'd0;
        tick();
        check_val("sweep_q2", q2, 8'hC3);
        check_val("sweep_qv2", qv2, 1);
        tick();
        check_val("sweep_bubble", qv2, 0);

        // Stall
        d = {8'h00, 8'h5A, 8'h00}; sel = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_qv", qv2, 0);
            check_val("stall_d1_hold", q1, 8'h5A);
        end
        en = 1'b1;
        tick();
        check_val("stall_q", q2, 8'h5A);
        check_val("stall_qv_out", qv2, 1);
        tick();
        check_val("stall_no_dup", qv2, 0);

        // Out-of-range select
        sel = 2'd3; in_valid = 1'b1;
        tick();
        check_val("oor_err", err2, 1);
        check_val("oor_d1_qv", qv1, 0);
        in_valid = 1'b0; sel = 2'd0;
        tick();
        check_val("oor_slot_qv", qv2, 0);
        check_val("oor_slot_q", q2, 8'h00);

        // Flush a full pipe
        in_valid = 1'b1; d = {8'h00, 8'h00, 8'h11};
        tick();
        d = {8'h00, 8'h00, 8'h22};
        tick();
        check_val("fill_q", q2, 8'h11);
        check_val("fill_qv", qv2, 1);
        flush = 1'b1; d = {8'h00, 8'h00, 8'h33};
        tick();
        check_val("flush_qv", qv2, 0);
        check_val("flush_q", q2, 8'h00);
        check_val("flush_keeps_err", err2, 1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_val("flush_drop_a", qv2, 0);
        tick();
        check_val("flush_drop_b", qv2, 0);

        // Reset clears the sticky flag; flush or stall blocks setting it
        rst = 1'b1;
        tick();
        check_val("err_cleared", err2, 0);
        rst = 1'b0; flush = 1'b1; sel = 2'd3; in_valid = 1'b1;
        tick();
        check_val("flush_vs_oor", err2, 0);
        flush = 1'b0; en = 1'b0;
        tick();
        check_val("stall_vs_oor", err2, 0);

        // DEPTH=1 all-ones sample
        en = 1'b1; sel = 2'd0; d = {8'h00, 8'h00, 8'hFF};
        tick();
        check_val("d1_ff_q", q1, 8'hFF);
        check_val("d1_ff_qv", qv1, 1);
        check_val("d1_err", err1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
